per_train_sched: RTL and testbench

- Training-sequence controller for the perceptron core.
- Walks the sample memories (x1, x2, label) one address at a time and drives the core's 4-bit phase-control word through read, calculate and update for each sample.
- Skips the update when the sample was classified correctly, counts errors per epoch, and repeats epochs until an error-free epoch (converged), an epoch limit, an abort, or a phase timeout.

---
 rtl/per_train_sched.sv | 193 +++++++++++++++++++
 tb/tb_per_train_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/per_train_sched.sv
// per_train_sched: walks the sample memories one address at a time and sequences the perceptron
// core through READ/CALC/UPD for each sample. An epoch is one pass over all samples. Training
// repeats epochs until an epoch has no errors, the epoch limit is reached, abort is seen, or a phase times out.
// Ports: start/abort/n_samples/max_epochs control the run. phase_done/err_flag come from the core.
//        core_ctrl/sample_addr drive the core. busy/done/converged/timeout/epoch_cnt/err_cnt report status.
// Latency: start to READ is 1 cycle. Each sample adds 1 NEXT cycle and each epoch adds 1 EPOCH cycle.
//          done is asserted 1 cycle after the final decision.
// Backpressure: each phase holds core_ctrl until phase_done arrives, or until the watchdog expires.
module per_train_sched #(
    parameter int ADDR_W  = 11,
    parameter int EPOCH_W = 8,
    parameter int TMO_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [ADDR_W-1:0]  n_samples,
    input  logic [EPOCH_W-1:0] max_epochs,
    input  logic               phase_done,
    input  logic               err_flag,
    output logic [3:0]         core_ctrl,
    output logic [ADDR_W-1:0]  sample_addr,
    output logic               busy,
    output logic               done,
    output logic               converged,
    output logic               timeout,
    output logic [EPOCH_W-1:0] epoch_cnt,
    output logic [ADDR_W-1:0]  err_cnt
);
    localparam int WD_W = $clog2(TMO_CYC + 1);

    typedef enum logic [2:0] {IDLE, READ, CALC, UPD, NEXT, EPOCH, FIN} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  nsamp_q, nsamp_d;
    logic [EPOCH_W-1:0] maxep_q, maxep_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  err_q, err_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic [3:0]         ctrl_q, ctrl_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               conv_q, conv_d;
    logic               tmo_q, tmo_d;
    logic               wd_expired;
    logic               in_phase_d;

    // The watchdog holds the number of cycles already spent in the current phase.
    // When it equals TMO_CYC-1, the current cycle is the last one allowed for the phase.
    assign wd_expired = (wdog_q == WD_W'(TMO_CYC - 1));
    assign in_phase_d = (state_d == READ) || (state_d == CALC) || (state_d == UPD);

    always_comb begin
        state_d = state_q;
        nsamp_d = nsamp_q;
        maxep_d = maxep_q;
        addr_d  = addr_q;
        err_d   = err_q;
        epoch_d = epoch_q;
        conv_d  = conv_q;
        tmo_d   = tmo_q;

        unique case (state_q)
            IDLE: begin
                if (start && (n_samples != '0) && (max_epochs != '0)) begin
                    nsamp_d = n_samples;
                    maxep_d = max_epochs;
                    conv_d  = 1'b0;
                    tmo_d   = 1'b0;
                    epoch_d = '0;
                    err_d   = '0;
                    addr_d  = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (phase_done) begin
                    state_d = CALC;
                end else if (wd_expired) begin
                    tmo_d   = 1'b1;
                    state_d = FIN;
                end
            end
            CALC: begin
                if (phase_done) begin
                    if (err_flag) begin
                        err_d   = (err_q == '1) ? err_q : err_q + ADDR_W'(1);
                        state_d = UPD;
                    end else begin
                        state_d = NEXT;
                    end
                end else if (wd_expired) begin
                    tmo_d   = 1'b1;
                    state_d = FIN;
                end
            end
            UPD: begin
                if (phase_done) begin
                    state_d = NEXT;
                end else if (wd_expired) begin
                    tmo_d   = 1'b1;
                    state_d = FIN;
                end
            end
            NEXT: begin
                if (abort) begin
                    state_d = FIN;
                end else if (addr_q == nsamp_q - ADDR_W'(1)) begin
                    state_d = EPOCH;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = READ;
                end
            end
            EPOCH: begin
                // The epoch has completed, so count it even if abort stops the run now.
                epoch_d = epoch_q + EPOCH_W'(1);
                if (abort) begin
                    state_d = FIN;
                end else if (err_q == '0) begin
                    conv_d  = 1'b1;
                    state_d = FIN;
                end else if (epoch_q + EPOCH_W'(1) == maxep_q) begin
                    state_d = FIN;
                end else begin
                    err_d   = '0;
                    addr_d  = '0;
                    state_d = READ;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // All outputs are decoded from the next state, so they change together with the state.
        unique case (state_d)
            READ:    ctrl_d = 4'b0011;
            CALC:    ctrl_d = 4'b0100;
            UPD:     ctrl_d = 4'b1000;
            default: ctrl_d = 4'b0000;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
        // Any state change re-arms the watchdog.
        // Consecutive phases always differ, so this also clears it on every phase entry.
        wdog_d = (state_d != state_q || !in_phase_d) ? '0 : wdog_q + WD_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            nsamp_q <= '0;
            maxep_q <= '0;
            addr_q  <= '0;
            err_q   <= '0;
            epoch_q <= '0;
            wdog_q  <= '0;
            ctrl_q  <= 4'b0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            conv_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            nsamp_q <= nsamp_d;
            maxep_q <= maxep_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            epoch_q <= epoch_d;
            wdog_q  <= wdog_d;
            ctrl_q  <= ctrl_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            conv_q  <= conv_d;
            tmo_q   <= tmo_d;
        end
    end

    assign core_ctrl   = ctrl_q;
    assign sample_addr = addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign converged   = conv_q;
    assign timeout     = tmo_q;
    assign epoch_cnt   = epoch_q;
    assign err_cnt     = err_q;
endmodule

// File: tb/tb_per_train_sched.sv
// tb_per_train_sched: directed runs of the training sequencer against a responsive core model.
// The reference model derives the phase sequence, the final counters and the done cycle from the
// training rules. Every cycle of each run is compared against that model.
module tb_per_train_sched;
    localparam int AW  = 11;
    localparam int EW  = 8;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          rst, start, abort, phase_done, err_flag;
    logic [AW-1:0] n_samples;
    logic [EW-1:0] max_epochs;
    logic [3:0]    core_ctrl;
    logic [AW-1:0] sample_addr;
    logic          busy, done, converged, timeout;
    logic [EW-1:0] epoch_cnt;
    logic [AW-1:0] err_cnt;

    per_train_sched #(.ADDR_W(AW), .EPOCH_W(EW), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .n_samples(n_samples), .max_epochs(max_epochs),
        .phase_done(phase_done), .err_flag(err_flag),
        .core_ctrl(core_ctrl), .sample_addr(sample_addr), .busy(busy), .done(done),
        .converged(converged), .timeout(timeout), .epoch_cnt(epoch_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    ctrl;
        logic [AW-1:0] addr;
    } ph_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] err_mask [16];   // err_mask[epoch][addr]: the core reports a misclassification
    ph_t         expq [$];
    int          exp_fin, exp_ep, exp_err;
    bit          exp_conv, exp_tmo;
    int          last_done_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mask();
        for (int i = 0; i < 16; i++) err_mask[i] = 16'h0;
    endtask

    // Reference model. Cycle 1 is the first READ cycle.
    // READ and UPD take d cycles each, and CALC takes dc cycles. dc == 0 means CALC never finishes.
    // Each sample adds 1 NEXT cycle and each epoch adds 1 EPOCH cycle.
    // An abort in the NEXT cycle after sample abort_s of the first epoch ends the run there.
    task automatic build_model(input int n, input int maxe, input int d, input int dc, input int abort_s);
        int  cyc;
        int  ep;
        int  errs;
        bit  stop;
        cyc = 1; ep = 0; errs = 0; stop = 0;
        expq.delete();
        exp_conv = 0; exp_tmo = 0;
        while (!stop) begin
            errs = 0;
            for (int a = 0; a < n && !stop; a++) begin
                expq.push_back({4'b0011, AW'(a)});
                cyc += d;
                expq.push_back({4'b0100, AW'(a)});
                if (dc == 0) begin
                    cyc += TMO;
                    exp_tmo = 1;
                    stop = 1;
                end else begin
                    cyc += dc;
                    if (err_mask[ep][a]) begin
                        expq.push_back({4'b1000, AW'(a)});
                        cyc += d;
                        errs++;
                    end
                    cyc += 1;
                    if (abort_s == a && ep == 0) stop = 1;
                end
            end
            if (!stop) begin
                ep++;
                cyc += 1;
                if (errs == 0) begin
                    exp_conv = 1;
                    stop = 1;
                end else if (ep == maxe) begin
                    stop = 1;
                end
            end
        end
        exp_fin = cyc; exp_ep = ep; exp_err = errs;
    endtask

    // Runs one training sequence. This task also acts as the core and compares every cycle against the model.
    task automatic run_case(input string nm, input int n, input int maxe, input int d, input int dc,
                            input int abort_s, input bit poke, input bit rst_upd);
        logic [3:0] prev;
        int         pcnt, ep_seen, cyc, lat, ei;
        bit         fin_seen;
        ph_t        e;
        build_model(n, maxe, d, dc, abort_s);
        @(negedge clk);
        n_samples = AW'(n); max_epochs = EW'(maxe); start = 1'b1;
        @(negedge clk);
        start = 1'b0; prev = 4'b0000; pcnt = 0; ep_seen = -1; cyc = 1; fin_seen = 0;
        last_done_cyc = -1;
        while (!fin_seen && cyc <= exp_fin + 4) begin
            if (core_ctrl !== 4'b0000 && core_ctrl !== prev) begin
                pcnt = 1;
                if (core_ctrl == 4'b0011 && sample_addr == '0) ep_seen++;
                chk({nm, " phase available"}, (expq.size() != 0), 1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk({nm, " phase ctrl"}, core_ctrl, e.ctrl);
                    chk({nm, " phase addr"}, sample_addr, e.addr);
                end
            end else if (core_ctrl !== 4'b0000) begin
                pcnt++;
            end
            chk({nm, " busy"}, busy, (cyc <= exp_fin));
            if (rst_upd && core_ctrl == 4'b1000) begin
                rst = 1'b1; phase_done = 1'b0; err_flag = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                chk({nm, " rst core_ctrl"}, core_ctrl, 0);
                chk({nm, " rst sample_addr"}, sample_addr, 0);
                chk({nm, " rst busy"}, busy, 0);
                chk({nm, " rst done"}, done, 0);
                chk({nm, " rst converged"}, converged, 0);
                chk({nm, " rst timeout"}, timeout, 0);
                chk({nm, " rst epoch_cnt"}, epoch_cnt, 0);
                chk({nm, " rst err_cnt"}, err_cnt, 0);
                return;
            end
            if (done === 1'b1) begin
                fin_seen = 1;
                last_done_cyc = cyc;
                chk({nm, " done cycle"}, cyc, exp_fin);
                chk({nm, " epoch_cnt"}, epoch_cnt, exp_ep);
                chk({nm, " err_cnt"}, err_cnt, exp_err);
                chk({nm, " converged"}, converged, exp_conv);
                chk({nm, " timeout"}, timeout, exp_tmo);
                chk({nm, " fin core_ctrl"}, core_ctrl, 0);
                chk({nm, " phases left"}, expq.size(), 0);
            end
            lat = (core_ctrl == 4'b0100) ? dc : d;
            phase_done = (core_ctrl != 4'b0000) && (lat != 0) && (pcnt == lat);
            ei = (ep_seen < 0) ? 0 : (ep_seen > 15 ? 15 : ep_seen);
            err_flag = phase_done && (core_ctrl == 4'b0100) && err_mask[ei][sample_addr[3:0]];
            if (abort_s >= 0 && ep_seen == 0 && core_ctrl == 4'b0100 && sample_addr == AW'(abort_s))
                abort = 1'b1;
            start = poke && (cyc == 5);
            if (poke && cyc == 5) begin
                n_samples = AW'(1); max_epochs = EW'(1);
            end
            prev = core_ctrl;
            @(negedge clk);
            cyc++;
        end
        phase_done = 1'b0; err_flag = 1'b0; abort = 1'b0; start = 1'b0;
        chk({nm, " done seen"}, fin_seen, 1);
        chk({nm, " busy after done"}, busy, 0);
        chk({nm, " single done pulse"}, done, 0);
    endtask

    task automatic invalid_start(input string nm, input int n, input int maxe);
        @(negedge clk);
        n_samples = AW'(n); max_epochs = EW'(maxe); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk({nm, " busy"}, busy, 0);
            chk({nm, " done"}, done, 0);
            chk({nm, " core_ctrl"}, core_ctrl, 0);
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; phase_done = 1'b0; err_flag = 1'b0;
        n_samples = '0; max_epochs = '0;
        clear_mask();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset core_ctrl", core_ctrl, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset epoch_cnt", epoch_cnt, 0);
        chk("reset err_cnt", err_cnt, 0);
        chk("reset converged", converged, 0);

        // No errors: converges after one epoch. FIN is at cycle 1 + 6*2 + 3 + 1 = 17.
        run_case("clean", 3, 5, 2, 2, -1, 0, 0);
        chk("clean done cycle literal", last_done_cyc, 17);
        chk("clean epoch_cnt literal", epoch_cnt, 1);
        chk("clean converged literal", converged, 1);

        // Error at addr 1 in every epoch, so the epoch limit ends the run.
        // Each epoch takes 7*2 + 3 + 1 = 18 cycles, so FIN is at 37.
        // A start pulse and new limits mid-run must be ignored.
        clear_mask(); err_mask[0] = 16'h0002; err_mask[1] = 16'h0002;
        run_case("limit", 3, 2, 2, 2, -1, 1, 0);
        chk("limit done cycle literal", last_done_cyc, 37);
        chk("limit err_cnt literal", err_cnt, 1);
        chk("limit converged literal", converged, 0);

        // Errors at addrs 0 and 2 in epoch 1, none in epoch 2. FIN is at 1 + 20 + 16 = 37.
        clear_mask(); err_mask[0] = 16'h0005;
        run_case("rollover", 3, 10, 2, 2, -1, 0, 0);
        chk("rollover epoch_cnt literal", epoch_cnt, 2);
        chk("rollover converged literal", converged, 1);

        // CALC never finishes, so the watchdog fires. FIN is at 1 + 2 + 64 = 67.
        clear_mask();
        run_case("timeout", 3, 5, 2, 0, -1, 0, 0);
        chk("timeout done cycle literal", last_done_cyc, 67);
        chk("timeout flag literal", timeout, 1);

        // phase_done arrives on the 64th CALC cycle and must beat expiry. FIN is at 1 + 2 + 64 + 1 + 1 = 69.
        run_case("late done", 1, 5, 2, 64, -1, 0, 0);
        chk("late done cycle literal", last_done_cyc, 69);
        chk("late done timeout literal", timeout, 0);

        // Abort during CALC of sample 0, which has an error: the UPD phase still runs, then the run ends in NEXT.
        clear_mask(); err_mask[0] = 16'h0001;
        run_case("abort", 3, 5, 2, 2, 0, 0, 0);
        chk("abort done cycle literal", last_done_cyc, 8);
        chk("abort epoch_cnt literal", epoch_cnt, 0);
        chk("abort err_cnt literal", err_cnt, 1);

        invalid_start("zero samples", 0, 5);
        invalid_start("zero epochs", 3, 0);

        // Reset during UPD, then a normal run.
        clear_mask(); err_mask[0] = 16'h0001;
        run_case("reset mid-run", 3, 5, 2, 2, -1, 0, 1);
        clear_mask();
        run_case("after reset", 3, 5, 3, 1, -1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
